// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates a programmable-length burst of sums into a wide total behind valid/ready handshakes
module sum_accumulator #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic [CNT_W-1:0]  burst_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic             beat;
    logic [CNT_W-1:0] eff_len;
    logic [CNT_W-1:0] next_count;
    logic [ACC_W:0]   sum_wide;

    assign beat       = in_valid && in_ready;
    assign eff_len    = (burst_len == '0) ? CNT_W'(1) : burst_len;
    assign next_count = out_count + CNT_W'(1);
    assign sum_wide   = {1'b0, out_acc} + (ACC_W + 1)'(in_sum);

    // Burst FSM; every output is a register so the downstream sees a clean boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            len_q     <= '0;
        end else if (clear) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (beat) begin
                        len_q     <= eff_len;
                        out_acc   <= ACC_W'(in_sum);
                        out_count <= CNT_W'(1);
                        out_ovf   <= 1'b0;
                        if (eff_len == CNT_W'(1)) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        out_acc   <= sum_wide[ACC_W-1:0];
                        out_ovf   <= out_ovf | sum_wide[ACC_W];
                        out_count <= next_count;
                        if (next_count == len_q) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: table-driven and scoreboard-checked bench for sum_accumulator
module tb_sum_accumulator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_sum;
    logic [7:0]  burst_len;
    logic        out_ready;
    logic        in_ready, out_valid, out_ovf;
    logic [39:0] out_acc;
    logic [7:0]  out_count;
    logic        in_ready1, out_valid1, out_ovf1;
    logic [32:0] out_acc1;
    logic [7:0]  out_count1;

    int assertions = 0;
    int failures   = 0;

    typedef struct packed {
        logic [39:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [7:0]       len;
        logic [3:0]       n;
        logic [4:0][31:0] b;
        logic [3:0]       gap;
        logic [3:0]       hold;
        logic [39:0]      acc;
        logic [7:0]       cnt;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    sum_accumulator dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .burst_len(burst_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
    );

    sum_accumulator #(.DATA_W(32), .ACC_W(33), .CNT_W(8)) dut33 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready1), .in_sum(in_sum), .burst_len(burst_len),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_acc(out_acc1), .out_count(out_count1), .out_ovf(out_ovf1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on each accepted result
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clear) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_output", 64'(out_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_acc", 64'(out_acc), 64'(e.acc));
                chk("sb_count", 64'(out_count), 64'(e.cnt));
                chk("sb_ovf", 64'(out_ovf), 64'(e.ovf));
            end
        end
    end

    function automatic vec_t mk(input logic [7:0] len, input int n,
                                input logic [31:0] b0, b1, b2, b3, b4,
                                input int gap, input int hold,
                                input logic [39:0] acc, input logic [7:0] cnt);
        vec_t v;
        v.len = len; v.n = 4'(n);
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
        v.gap = 4'(gap); v.hold = 4'(hold); v.acc = acc; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive_beat(input logic [31:0] data, input logic [7:0] len);
        int t;
        in_valid  = 1'b1;
        in_sum    = data;
        burst_len = len;
        t = 0;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        in_sum   = $urandom;
    endtask

    task automatic run_burst(input vec_t v, input string tag);
        exp_t e;
        for (int k = 0; k < int'(v.n); k++) begin
            drive_beat(v.b[k], (k == 0) ? v.len : (v.len ^ 8'hA5));
            if (k == int'(v.n) - 1) begin
                e.acc = v.acc; e.cnt = v.cnt; e.ovf = 1'b0;
                sb.push_back(e);
            end else begin
                for (int g = 0; g < int'(v.gap); g++) step();
                chk({tag, "_not_done"}, 64'(out_valid), 64'(0));
            end
        end
        chk({tag, "_latency"}, 64'(out_valid), 64'(1));
        for (int h = 0; h < int'(v.hold); h++) begin
            chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'(0));
            chk({tag, "_hold_acc"}, 64'(out_acc), 64'(v.acc));
            chk({tag, "_hold_cnt"}, 64'(out_count), 64'(v.cnt));
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_released_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_released_ready"}, 64'(in_ready), 64'(1));
        chk({tag, "_persist_acc"}, 64'(out_acc), 64'(v.acc));
    endtask

    initial begin
        exp_t e;
        vecs[0] = mk(8'd4, 4, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 0, 0, 40'd10, 8'd4);
        vecs[1] = mk(8'd0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 40'h00FFFFFFFF, 8'd1);
        vecs[2] = mk(8'd3, 3, 32'd10, 32'd20, 32'd30, 0, 0, 2, 5, 40'd60, 8'd3);
        vecs[3] = mk(8'd1, 1, 32'd5, 0, 0, 0, 0, 0, 2, 40'd5, 8'd1);
        vecs[4] = mk(8'd2, 2, 32'h80000000, 32'h80000000, 0, 0, 0, 1, 0, 40'h0100000000, 8'd2);
        vecs[5] = mk(8'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     0, 1, 40'h04FFFFFFFB, 8'd5);

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_sum = '0; burst_len = '0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_acc", 64'(out_acc), 64'(0));
        chk("rst_out_count", 64'(out_count), 64'(0));
        chk("rst_out_ovf", 64'(out_ovf), 64'(0));
        #10 rst_n = 1'b1;
        #1 chk("rst_release_ready_wait", 64'(in_ready), 64'(0));
        step();
        chk("rst_release_ready", 64'(in_ready), 64'(1));

        for (int i = 0; i < 6; i++) run_burst(vecs[i], $sformatf("vec%0d", i));

        // ACC_W=33 wrap and sticky overflow
        drive_beat(32'hFFFFFFFF, 8'd3);
        drive_beat(32'hFFFFFFFF, 8'd3);
        drive_beat(32'hFFFFFFFF, 8'd3);
        e.acc = 40'h02FFFFFFFD; e.cnt = 8'd3; e.ovf = 1'b0;
        sb.push_back(e);
        chk("ovf33_valid", 64'(out_valid1), 64'(1));
        chk("ovf33_acc", 64'(out_acc1), 64'h0FFFFFFFD);
        chk("ovf33_ovf", 64'(out_ovf1), 64'(1));
        chk("ovf33_count", 64'(out_count1), 64'(3));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // clear with a concurrent beat drops the partial burst
        drive_beat(32'd100, 8'd5);
        drive_beat(32'd200, 8'd5);
        in_valid = 1'b1; in_sum = 32'd999; clear = 1'b1;
        step();
        in_valid = 1'b0; clear = 1'b0;
        chk("clear_valid", 64'(out_valid), 64'(0));
        chk("clear_acc", 64'(out_acc), 64'(0));
        chk("clear_count", 64'(out_count), 64'(0));
        chk("clear_ready", 64'(in_ready), 64'(1));
        run_burst(mk(8'd2, 2, 32'd7, 32'd8, 0, 0, 0, 0, 0, 40'd15, 8'd2), "after_clear");

        // asynchronous reset mid-ACCUM
        drive_beat(32'd9, 8'd4);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_accum_ready", 64'(in_ready), 64'(0));
        chk("arst_accum_acc", 64'(out_acc), 64'(0));
        #8 rst_n = 1'b1;
        step();
        // asynchronous reset mid-HOLD
        drive_beat(32'd3, 8'd1);
        chk("hold_before_arst", 64'(out_valid), 64'(1));
        #3 rst_n = 1'b0;
        #1;
        chk("arst_hold_valid", 64'(out_valid), 64'(0));
        chk("arst_hold_ready", 64'(in_ready), 64'(0));
        chk("arst_hold_count", 64'(out_count), 64'(0));
        #8 rst_n = 1'b1;
        step();
        chk("arst_release_ready", 64'(in_ready), 64'(1));
        run_burst(mk(8'd2, 2, 32'd5, 32'd6, 0, 0, 0, 0, 0, 40'd11, 8'd2), "after_arst");

        step();
        step();
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
